// File: rtl/memory_stage.sv
// Memory stage: issues loads/stores on a req/gnt/rvalid bus, aligns store data,
// extracts/extends load data and registers the MEM->WB results.
module memory_stage #(
  parameter int unsigned DMEM_AW     = 64,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               stall_i,
  input  logic               valid_i,
  input  logic [63:0]        alu_res_i,
  input  logic [63:0]        rs2_data_i,
  input  logic [63:0]        rd_data_i,
  input  logic [4:0]         rd_idx_i,
  input  logic               rd_wr_en_i,
  input  logic [2:0]         rd_wr_src_1h_i,
  input  logic [3:0]         mem_width_1h_i,
  input  logic               mem_rd_i,
  input  logic               mem_wr_i,
  input  logic               mem_sign_i,
  output logic               dmem_req_o,
  input  logic               dmem_gnt_i,
  output logic               dmem_we_o,
  output logic [7:0]         dmem_be_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [63:0]        dmem_wdata_o,
  input  logic               dmem_rvalid_i,
  input  logic [63:0]        dmem_rdata_i,
  output logic               mem_stall_ao,
  output logic               valid_o,
  output logic [4:0]         rd_idx_o,
  output logic               rd_wr_en_o,
  output logic [63:0]        rd_data_o,
  output logic               misaligned_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RV, HOLD} state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [4:0]  rd_idx_q, rd_idx_d;
  logic        rd_wr_en_q, rd_wr_en_d;
  logic [63:0] rd_data_q, rd_data_d;
  logic        misaligned_q, misaligned_d;
  logic [63:0] rdata_q, rdata_d;

  logic [2:0]  off;
  logic [5:0]  bit_off;
  logic        mem_op, misalign, fault, acc;
  logic [7:0]  be;
  logic [63:0] rsrc, rshift, load_data;
  logic        req, stall, commit, capture;
  logic        unused_src;

  assign off        = alu_res_i[2:0];
  assign bit_off    = {off, 3'b000};
  assign unused_src = ^rd_wr_src_1h_i;

  assign mem_op   = valid_i & (mem_rd_i | mem_wr_i);
  assign misalign = ~$onehot(mem_width_1h_i)
                  | (mem_width_1h_i[1] & off[0])
                  | (mem_width_1h_i[2] & (|off[1:0]))
                  | (mem_width_1h_i[3] & (|off));
  assign fault    = mem_op & ALIGN_CHECK & misalign;
  assign acc      = mem_op & ~fault;

  always_comb begin
    be = 8'h00;
    if (mem_width_1h_i[3])      be = 8'hFF;
    else if (mem_width_1h_i[2]) be = 8'h0F << off;
    else if (mem_width_1h_i[1]) be = 8'h03 << off;
    else if (mem_width_1h_i[0]) be = 8'h01 << off;
  end

  assign dmem_we_o    = mem_wr_i;
  assign dmem_be_o    = be;
  assign dmem_addr_o  = {alu_res_i[DMEM_AW-1:3], 3'b000};
  assign dmem_wdata_o = rs2_data_i << bit_off;

  // A load committing out of HOLD uses the doubleword captured at rvalid.
  assign rsrc   = (state_q == HOLD) ? rdata_q : dmem_rdata_i;
  assign rshift = rsrc >> bit_off;

  always_comb begin
    load_data = rshift;
    if (mem_width_1h_i[0])
      load_data = {{56{mem_sign_i & rshift[7]}}, rshift[7:0]};
    else if (mem_width_1h_i[1])
      load_data = {{48{mem_sign_i & rshift[15]}}, rshift[15:0]};
    else if (mem_width_1h_i[2])
      load_data = {{32{mem_sign_i & rshift[31]}}, rshift[31:0]};
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    commit  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE, WAIT_GNT: begin
        req = acc;
        if (!acc) begin
          commit  = ~stall_i;
          state_d = IDLE;
        end else if (!dmem_gnt_i) begin
          stall   = 1'b1;
          state_d = WAIT_GNT;
        end else if (mem_wr_i) begin
          if (stall_i) begin
            state_d = HOLD;
          end else begin
            commit  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          stall   = 1'b1;
          state_d = WAIT_RV;
        end
      end
      WAIT_RV: begin
        if (dmem_rvalid_i) begin
          if (stall_i) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            commit  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          stall = 1'b1;
        end
      end
      HOLD: begin
        if (!stall_i) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The request is masked by reset so it drops the moment rst_ni falls.
  assign dmem_req_o   = req & rst_ni;
  assign mem_stall_ao = stall;

  always_comb begin
    valid_d      = valid_q;
    rd_idx_d     = rd_idx_q;
    rd_wr_en_d   = rd_wr_en_q;
    rd_data_d    = rd_data_q;
    misaligned_d = misaligned_q;
    rdata_d      = capture ? dmem_rdata_i : rdata_q;
    if (commit) begin
      valid_d      = valid_i;
      rd_idx_d     = rd_idx_i;
      rd_wr_en_d   = rd_wr_en_i & ~fault;
      rd_data_d    = mem_rd_i ? load_data : rd_data_i;
      misaligned_d = fault;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      rd_idx_q     <= 5'd0;
      rd_wr_en_q   <= 1'b0;
      rd_data_q    <= 64'd0;
      misaligned_q <= 1'b0;
      rdata_q      <= 64'd0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      rd_idx_q     <= rd_idx_d;
      rd_wr_en_q   <= rd_wr_en_d;
      rd_data_q    <= rd_data_d;
      misaligned_q <= misaligned_d;
      rdata_q      <= rdata_d;
    end
  end

  assign valid_o      = valid_q;
  assign rd_idx_o     = rd_idx_q;
  assign rd_wr_en_o   = rd_wr_en_q;
  assign rd_data_o    = rd_data_q;
  assign misaligned_o = misaligned_q;

endmodule
